// File: rtl/mul_seq_ctrl_pkg.sv
// Shared definitions for the signed serial multiplier sequencer:
// FSM state encodings, default widths shared with the multiplier top,
// and a small elaboration-time helper.
package mul_seq_ctrl_pkg;

  localparam int DEF_X_WIDTH        = 8;
  localparam int DEF_Y_WIDTH        = 8;
  localparam int DEF_Z_WIDTH        = DEF_X_WIDTH + DEF_Y_WIDTH;
  localparam int DEF_CNT_WIDTH      = 5;
  localparam int DEF_ZOUT_LAT       = 1;
  localparam int DEF_TIMEOUT_CYCLES = 255;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    WAIT_F = 3'd2,
    MUL    = 3'd3,
    SHOUT  = 3'd4,
    RESP   = 3'd5
  } mseq_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mul_seq_ctrl_if.sv
// Host-side operand/result handshakes of the multiplier sequencer.
// master = host bus logic, slave = sequencer.
interface mul_seq_ctrl_if
  import mul_seq_ctrl_pkg::*;
#(
  parameter int X_WIDTH = DEF_X_WIDTH,
  parameter int Y_WIDTH = DEF_Y_WIDTH,
  parameter int Z_WIDTH = X_WIDTH + Y_WIDTH
);

  logic               op_valid;
  logic               op_ready;
  logic [X_WIDTH-1:0] op_x;
  logic [Y_WIDTH-1:0] op_y;
  logic               res_valid;
  logic               res_ready;
  logic [Z_WIDTH-1:0] res_z;

  modport master (
    output op_valid, op_x, op_y, res_ready,
    input  op_ready, res_valid, res_z
  );

  modport slave (
    input  op_valid, op_x, op_y, res_ready,
    output op_ready, res_valid, res_z
  );

endinterface

// File: rtl/mul_seq_ser.sv
// Parallel-load, LSB-first serializer. A load starts a burst of exactly
// WIDTH shift-enable cycles; the bit presented while sen is high is the
// one the datapath shifts in at the end of that cycle.
module mul_seq_ser #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 5
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  output logic             sdata,
  output logic             sen
);

  logic [WIDTH-1:0]     sr;
  logic [CNT_WIDTH-1:0] left;

  // Load the operand, then shift right once per enabled cycle until the
  // remaining-bit down-counter hits its terminal count.
  always_ff @(posedge Clk) begin
    if (!reset) begin
      sr   <= '0;
      left <= '0;
      sen  <= 1'b0;
    end else if (load) begin
      sr   <= data;
      left <= CNT_WIDTH'(WIDTH);
      sen  <= 1'b1;
    end else if (sen) begin
      sr   <= sr >> 1;
      left <= left - CNT_WIDTH'(1);
      sen  <= (left != CNT_WIDTH'(1));
    end
  end

  assign sdata = sr[0];

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequencer for the signed serial multiplier datapath.
// Optional watchdog: define MSEQ_TIMEOUT_EN to add the per-wait-state
// timeout counter and the sticky timeout output.
//
// state  | meaning
// IDLE   | op_ready high, waiting for an operand pair
// LOAD   | shifting X/Y into the datapath, LSB first
// WAIT_F | waiting for both shift-in complete flags
// MUL    | Mul held high until Don
// SHOUT  | Sz high, deserializing Z_out until Fz
// RESP   | res_valid high until the host takes the product
module mul_seq_ctrl
  import mul_seq_ctrl_pkg::*;
#(
  parameter int X_WIDTH   = DEF_X_WIDTH,
  parameter int Y_WIDTH   = DEF_Y_WIDTH,
  parameter int Z_WIDTH   = X_WIDTH + Y_WIDTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH,
  parameter int ZOUT_LAT  = DEF_ZOUT_LAT
`ifdef MSEQ_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
  input  logic          Clk,
  input  logic          reset,
  mul_seq_ctrl_if.slave bus,
  output logic          busy,
  output logic          X_in,
  output logic          Sx,
  output logic          Y_in,
  output logic          Sy,
  input  logic          Fx,
  input  logic          Fy,
  output logic          Mul,
  input  logic          Don,
  output logic          Sz,
  input  logic          Z_out,
  input  logic          Fz
`ifdef MSEQ_TIMEOUT_EN
  , output logic        timeout
`endif
);

  localparam int MAX_W = max_int(X_WIDTH, Y_WIDTH);
  localparam logic [CNT_WIDTH-1:0] LOAD_LAST = CNT_WIDTH'(MAX_W - 1);
  localparam logic [CNT_WIDTH-1:0] Z_CNT     = CNT_WIDTH'(Z_WIDTH);
  localparam logic [CNT_WIDTH-1:0] LAT_INIT  = CNT_WIDTH'(ZOUT_LAT);

  mseq_state_e          state;
  logic [CNT_WIDTH-1:0] load_cnt;
  logic [CNT_WIDTH-1:0] lat_cnt;
  logic [CNT_WIDTH-1:0] samp_cnt;
  logic [CNT_WIDTH-1:0] n_next;
  logic [CNT_WIDTH-1:0] z_shamt;
  logic [Z_WIDTH-1:0]   z_sr;
  logic [Z_WIDTH-1:0]   z_next;
  logic [Z_WIDTH-1:0]   z_final;
  logic [Z_WIDTH-1:0]   res_z_q;
  logic                 op_ready_q;
  logic                 res_valid_q;
  logic                 z_take;
  logic                 accept;

  assign accept        = (state == IDLE) && bus.op_valid;
  assign bus.op_ready  = op_ready_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_z     = res_z_q;

  mul_seq_ser #(.WIDTH(X_WIDTH), .CNT_WIDTH(CNT_WIDTH)) u_ser_x (
    .Clk   (Clk),
    .reset (reset),
    .load  (accept),
    .data  (bus.op_x),
    .sdata (X_in),
    .sen   (Sx)
  );

  mul_seq_ser #(.WIDTH(Y_WIDTH), .CNT_WIDTH(CNT_WIDTH)) u_ser_y (
    .Clk   (Clk),
    .reset (reset),
    .load  (accept),
    .data  (bus.op_y),
    .sdata (Y_in),
    .sen   (Sy)
  );

  // Z deserializer: bits arrive LSB first into the top of z_sr. If Fz cuts
  // the stream short, the arithmetic shift moves the sampled bits down and
  // replicates the last one as the sign.
  always_comb begin
    z_take  = (state == SHOUT) && (lat_cnt == '0) && (samp_cnt != Z_CNT);
    z_next  = z_take ? {Z_out, z_sr[Z_WIDTH-1:1]} : z_sr;
    n_next  = z_take ? (samp_cnt + CNT_WIDTH'(1)) : samp_cnt;
    z_shamt = Z_CNT - n_next;
    z_final = $signed(z_next) >>> z_shamt;
  end

`ifdef MSEQ_TIMEOUT_EN
  localparam int WD_WIDTH = max_int(8, $clog2(TIMEOUT_CYCLES + 1));
  localparam logic [WD_WIDTH-1:0] WD_INIT = WD_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [WD_WIDTH-1:0] wd_cnt;
  logic                in_wait;
  logic                wait_stay;

  // A wait state "stays" when its exit condition is absent this cycle;
  // only those cycles run the watchdog down.
  always_comb begin
    in_wait   = (state == WAIT_F) || (state == MUL) || (state == SHOUT);
    wait_stay = ((state == WAIT_F) && !(Fx && Fy)) ||
                ((state == MUL)    && !Don)        ||
                ((state == SHOUT)  && !Fz);
  end
`endif

  // Main sequencing FSM with registered strobes and handshake outputs.
  always_ff @(posedge Clk) begin
    if (!reset) begin
      state       <= IDLE;
      load_cnt    <= '0;
      lat_cnt     <= '0;
      samp_cnt    <= '0;
      z_sr        <= '0;
      res_z_q     <= '0;
      op_ready_q  <= 1'b1;
      res_valid_q <= 1'b0;
      busy        <= 1'b0;
      Mul         <= 1'b0;
      Sz          <= 1'b0;
`ifdef MSEQ_TIMEOUT_EN
      wd_cnt      <= '0;
      timeout     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state      <= LOAD;
            op_ready_q <= 1'b0;
            busy       <= 1'b1;
            load_cnt   <= LOAD_LAST;
          end
        end
        LOAD: begin
          if (load_cnt == '0) begin
            state <= WAIT_F;
          end else begin
            load_cnt <= load_cnt - CNT_WIDTH'(1);
          end
        end
        WAIT_F: begin
          if (Fx && Fy) begin
            state <= MUL;
            Mul   <= 1'b1;
          end
        end
        MUL: begin
          if (Don) begin
            state    <= SHOUT;
            Mul      <= 1'b0;
            Sz       <= 1'b1;
            lat_cnt  <= LAT_INIT;
            samp_cnt <= '0;
            z_sr     <= '0;
          end
        end
        SHOUT: begin
          if (lat_cnt != '0) begin
            lat_cnt <= lat_cnt - CNT_WIDTH'(1);
          end
          z_sr     <= z_next;
          samp_cnt <= n_next;
          if (Fz) begin
            state       <= RESP;
            Sz          <= 1'b0;
            res_valid_q <= 1'b1;
            res_z_q     <= z_final;
          end
        end
        RESP: begin
          if (bus.res_ready) begin
            state       <= IDLE;
            res_valid_q <= 1'b0;
            op_ready_q  <= 1'b1;
            busy        <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
`ifdef MSEQ_TIMEOUT_EN
      // Reload on every entry into / exit from a wait state; on expiry the
      // watchdog overrides the case above and forces an empty response.
      if (!in_wait || !wait_stay) begin
        wd_cnt <= WD_INIT;
      end else if (wd_cnt != '0) begin
        wd_cnt <= wd_cnt - WD_WIDTH'(1);
      end else begin
        timeout     <= 1'b1;
        state       <= RESP;
        Mul         <= 1'b0;
        Sz          <= 1'b0;
        res_valid_q <= 1'b1;
        res_z_q     <= '0;
        wd_cnt      <= WD_INIT;
      end
`endif
    end
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Bench for mul_seq_ctrl with a behavioural serial multiplier datapath.
// Define MSEQ_TIMEOUT_EN to also exercise the watchdog (TIMEOUT_CYCLES=16).
module tb_mul_seq_ctrl;

  logic Clk = 1'b0;
  logic reset = 1'b0;
  logic busy, X_in, Sx, Y_in, Sy, Fx, Fy, Mul, Don, Sz, Z_out, Fz;
`ifdef MSEQ_TIMEOUT_EN
  logic timeout;
`endif

  int n_chk = 0;
  int n_bad = 0;

  mul_seq_ctrl_if #(.X_WIDTH(8), .Y_WIDTH(8)) bus ();

  mul_seq_ctrl #(
    .X_WIDTH(8),
    .Y_WIDTH(8)
`ifdef MSEQ_TIMEOUT_EN
    , .TIMEOUT_CYCLES(16)
`endif
  ) dut (
    .Clk   (Clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy),
    .X_in  (X_in),
    .Sx    (Sx),
    .Y_in  (Y_in),
    .Sy    (Sy),
    .Fx    (Fx),
    .Fy    (Fy),
    .Mul   (Mul),
    .Don   (Don),
    .Sz    (Sz),
    .Z_out (Z_out),
    .Fz    (Fz)
`ifdef MSEQ_TIMEOUT_EN
    , .timeout (timeout)
`endif
  );

  always #5 Clk = ~Clk;

  // behavioural datapath
  logic [7:0]         mx = '0;
  logic [7:0]         my = '0;
  logic signed [15:0] prod = '0;
  int                 xcnt = 0;
  int                 ycnt = 0;
  int                 zcnt = 0;
  logic               don_r = 1'b0;
  logic               fz_r = 1'b0;
  logic               zo = 1'b0;
  bit                 fy_hold = 1'b0;
  bit                 don_block = 1'b0;
  bit                 fz_early = 1'b0;

  always @(posedge Clk) begin
    if (!reset || (bus.op_valid && bus.op_ready)) begin
      xcnt <= 0;
      ycnt <= 0;
    end else begin
      if (Sx) begin
        mx   <= {X_in, mx[7:1]};
        xcnt <= xcnt + 1;
      end
      if (Sy) begin
        my   <= {Y_in, my[7:1]};
        ycnt <= ycnt + 1;
      end
    end
    if (Mul) prod <= $signed(mx) * $signed(my);
    don_r <= reset && Mul && !don_block;
    if (reset && Sz) begin
      if (zcnt < 16) zo <= prod[zcnt];
      zcnt <= zcnt + 1;
    end else begin
      zcnt <= 0;
    end
    fz_r <= reset && Sz && (zcnt >= 16);
  end

  assign Fx    = (xcnt == 8);
  assign Fy    = (ycnt == 8) && !fy_hold;
  assign Don   = don_r;
  assign Z_out = zo;
  assign Fz    = fz_r || (fz_early && Sz && (zcnt == 6));

  typedef struct {
    logic [7:0]  x;
    logic [7:0]  y;
    logic [15:0] z;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic send_op(input logic [7:0] x, input logic [7:0] y);
    @(negedge Clk);
    chk("op_ready_idle", 32'(bus.op_ready), 32'd1);
    bus.op_valid = 1'b1;
    bus.op_x     = x;
    bus.op_y     = y;
    @(negedge Clk);
    bus.op_valid = 1'b0;
  endtask

  task automatic wait_res(output int lat);
    lat = 0;
    while (!bus.res_valid && lat < 200) begin
      @(negedge Clk);
      lat++;
    end
    chk("res_valid_seen", 32'(bus.res_valid), 32'd1);
  endtask

  task automatic take_res();
    bus.res_ready = 1'b1;
    @(negedge Clk);
    bus.res_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          lat;
    int          guard;
    bit          flag;
    logic [15:0] z0;

    vecs[0] = '{8'hFD, 8'h05, 16'hFFF1};
    vecs[1] = '{8'h80, 8'h80, 16'h4000};
    vecs[2] = '{8'h7F, 8'h81, 16'hC0FF};
    vecs[3] = '{8'h02, 8'h03, 16'h0006};
    vecs[4] = '{8'hFF, 8'hFF, 16'h0001};
    vecs[5] = '{8'h00, 8'h7F, 16'h0000};
    vecs[6] = '{8'h7F, 8'h7F, 16'h3F01};
    vecs[7] = '{8'h80, 8'h7F, 16'hC080};

    bus.op_valid  = 1'b0;
    bus.op_x      = '0;
    bus.op_y      = '0;
    bus.res_ready = 1'b0;
    repeat (3) @(negedge Clk);
    chk("reset_outputs", 32'({bus.op_ready, bus.res_valid, busy, Sx, Sy, Mul, Sz}), 32'b1000000);
    chk("reset_res_z", 32'(bus.res_z), 32'h0);
    reset = 1'b1;

    // table: product and accept-to-res_valid latency
    for (int i = 0; i < 8; i++) begin
      send_op(vecs[i].x, vecs[i].y);
      wait_res(lat);
      chk($sformatf("vec%0d_res_z", i), 32'(bus.res_z), 32'(vecs[i].z));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd29);
      take_res();
    end

    // result stall with an ignored op_valid pulse
    send_op(8'hFD, 8'h05);
    wait_res(lat);
    z0   = bus.res_z;
    flag = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.op_valid = (i == 4);
      bus.op_x     = 8'h11;
      bus.op_y     = 8'h22;
      if (bus.res_z !== z0 || bus.op_ready !== 1'b0 || bus.res_valid !== 1'b1) flag = 1'b0;
      @(negedge Clk);
    end
    bus.op_valid = 1'b0;
    chk("stall_z", 32'(z0), 32'hFFF1);
    chk("stall_hold", 32'(flag), 32'd1);
    take_res();
    @(negedge Clk);
    chk("stall_no_accept", 32'({busy, bus.op_ready}), 32'b01);

    // reset during LOAD cycle 3
    send_op(8'h55, 8'h33);
    @(negedge Clk);
    reset = 1'b0;
    @(negedge Clk);
    chk("abort_outputs", 32'({bus.op_ready, bus.res_valid, busy, Sx, Sy, Mul, Sz}), 32'b1000000);
    reset = 1'b1;
    send_op(8'h02, 8'h03);
    wait_res(lat);
    chk("after_abort_z", 32'(bus.res_z), 32'h0006);
    take_res();

    // Fy delayed 20 cycles after Fx
    fy_hold = 1'b1;
    send_op(8'hFD, 8'h05);
    guard = 0;
    while (!Fx && guard < 50) begin
      @(negedge Clk);
      guard++;
    end
    chk("fx_seen", 32'(Fx), 32'd1);
    flag = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (Mul !== 1'b0) flag = 1'b0;
      @(negedge Clk);
    end
    chk("mul_waits_fy", 32'(flag), 32'd1);
    fy_hold = 1'b0;
    @(negedge Clk);
    chk("mul_after_fy", 32'(Mul), 32'd1);
    wait_res(lat);
    chk("fy_late_z", 32'(bus.res_z), 32'hFFF1);
    take_res();

    // Fz after only 6 samples: sign-extend from the last sampled bit
    fz_early = 1'b1;
    send_op(8'hFD, 8'h05);
    wait_res(lat);
    chk("fz_early_z", 32'(bus.res_z), 32'hFFF1);
    chk("fz_early_latency", 32'(lat), 32'd18);
    take_res();
    fz_early = 1'b0;

`ifdef MSEQ_TIMEOUT_EN
    // watchdog with Don never arriving
    don_block = 1'b1;
    send_op(8'h02, 8'h03);
    guard = 0;
    lat   = 0;
    while (!timeout && guard < 100) begin
      @(negedge Clk);
      guard++;
      if (Mul && !timeout) lat++;
    end
    chk("to_mul_cycles", 32'(lat), 32'd16);
    chk("to_outputs", 32'({timeout, bus.res_valid, Mul, Sz}), 32'b1100);
    chk("to_res_z", 32'(bus.res_z), 32'h0);
    take_res();
    repeat (3) @(negedge Clk);
    chk("to_sticky", 32'(timeout), 32'd1);
    reset = 1'b0;
    @(negedge Clk);
    reset = 1'b1;
    chk("to_cleared", 32'(timeout), 32'd0);
    don_block = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end

endmodule
